// File: rtl/zx_screen_pkg.sv
// Shared constants, command layout and the ZX interleaved pixel address map,
// used by both the screen writer and the scan-out side.
package zx_screen_pkg;

    localparam int PIX_BYTES  = 6144;
    localparam int ATTR_BYTES = 768;
    localparam int ATTR_BASE  = 6144;
    localparam int ROWS       = 24;
    localparam int COLS       = 32;

    localparam logic OP_CHAR = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef struct packed {
        logic       op;
        logic [4:0] row;
        logic [4:0] col;
        logic [7:0] chr;
        logic [7:0] attr;
    } zx_cmd_t;

    // y is the pixel line 0..191; thirds, line-in-cell and row-in-third are interleaved.
    function automatic logic [12:0] pix_addr(input logic [7:0] y, input logic [4:0] col);
        return {y[7:6], y[2:0], y[5:3], col};
    endfunction

endpackage

// File: rtl/zx_addr_gen.sv
// Combinational mapper from character cell (row, col) plus glyph line to the
// pixel byte address and the cell's attribute byte address.
module zx_addr_gen
    import zx_screen_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int ATTR_BASE = 6144,
    parameter int COLS      = 32
) (
    input  logic [4:0]        row,
    input  logic [2:0]        line,
    input  logic [4:0]        col,
    output logic [ADDR_W-1:0] pix,
    output logic [ADDR_W-1:0] attr
);

    assign pix  = ADDR_W'(pix_addr({row, line}, col));
    assign attr = ADDR_W'(ATTR_BASE) + ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

endmodule

// File: rtl/zx_screen_writer.sv
// Write-side engine for the ZX screen RAM: plots 8x8 glyph cells fetched from a
// synchronous font ROM and fills the whole screen, one RAM byte per cycle.
module zx_screen_writer
    import zx_screen_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int ATTR_BASE = 6144,
    parameter int ROWS      = 24,
    parameter int COLS      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [4:0]        cmd_col,
    input  logic [4:0]        cmd_row,
    input  logic [7:0]        cmd_char,
    input  logic [7:0]        cmd_attr,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              vram_we,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CH_FETCH = 3'd1;
    localparam logic [2:0] ST_CH_PIX   = 3'd2;
    localparam logic [2:0] ST_CH_ATTR  = 3'd3;
    localparam logic [2:0] ST_FL_PIX   = 3'd4;
    localparam logic [2:0] ST_FL_ATTR  = 3'd5;

    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(ATTR_BASE - 1);
    localparam logic [ADDR_W-1:0] ATTR_LAST = ADDR_W'(ATTR_BASE + ATTR_BYTES - 1);

    logic [2:0]        state_r;
    zx_cmd_t           cmd_r;
    logic [2:0]        line_r;
    logic [2:0]        line_nxt_s;
    logic [ADDR_W-1:0] vram_addr_r;
    logic [7:0]        din_r;
    logic              we_r;
    logic [10:0]       font_addr_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W-1:0] pix_s;
    logic [ADDR_W-1:0] attr_s;

    zx_addr_gen #(
        .ADDR_W    (ADDR_W),
        .ATTR_BASE (ATTR_BASE),
        .COLS      (COLS)
    ) u_addr_gen (
        .row  (cmd_r.row),
        .line (line_nxt_s),
        .col  (cmd_r.col),
        .pix  (pix_s),
        .attr (attr_s)
    );

    // Glyph line whose pixel address is loaded at the next edge.
    always_comb begin
        line_nxt_s = 3'd0;
        if (state_r == ST_CH_PIX) begin
            line_nxt_s = line_r + 3'd1;
        end else begin
            line_nxt_s = 3'd0;
        end
    end

    // Command sequencer; all write-port outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cmd_r       <= '0;
            line_r      <= 3'd0;
            vram_addr_r <= '0;
            din_r       <= 8'h00;
            we_r        <= 1'b0;
            font_addr_r <= 11'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_FILL) begin
                            cmd_r       <= '{op: cmd_op, row: cmd_row, col: cmd_col,
                                             chr: cmd_char, attr: cmd_attr};
                            vram_addr_r <= '0;
                            din_r       <= 8'h00;
                            we_r        <= 1'b1;
                            state_r     <= ST_FL_PIX;
                        end else if (cmd_row < 5'(ROWS)) begin
                            cmd_r       <= '{op: cmd_op, row: cmd_row, col: cmd_col,
                                             chr: cmd_char, attr: cmd_attr};
                            font_addr_r <= {cmd_char, 3'd0};
                            state_r     <= ST_CH_FETCH;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_CH_FETCH: begin
                    font_addr_r <= {cmd_r.chr, 3'd1};
                    vram_addr_r <= pix_s;
                    line_r      <= 3'd0;
                    we_r        <= 1'b1;
                    state_r     <= ST_CH_PIX;
                end
                ST_CH_PIX: begin
                    if (line_r == 3'd7) begin
                        vram_addr_r <= attr_s;
                        din_r       <= cmd_r.attr;
                        state_r     <= ST_CH_ATTR;
                    end else begin
                        line_r      <= line_r + 3'd1;
                        vram_addr_r <= pix_s;
                        // ROM stays one line ahead; nothing to prefetch past line 7.
                        if (line_r < 3'd6) begin
                            font_addr_r <= {cmd_r.chr, line_r + 3'd2};
                        end
                    end
                end
                ST_CH_ATTR: begin
                    we_r    <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                ST_FL_PIX: begin
                    vram_addr_r <= vram_addr_r + ADDR_W'(1);
                    if (vram_addr_r == PIX_LAST) begin
                        din_r   <= cmd_r.attr;
                        state_r <= ST_FL_ATTR;
                    end
                end
                ST_FL_ATTR: begin
                    if (vram_addr_r == ATTR_LAST) begin
                        we_r    <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        vram_addr_r <= vram_addr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign font_addr = font_addr_r;
    assign vram_addr = vram_addr_r;
    // Glyph bytes arrive from the ROM in the very cycle they are written.
    assign vram_din  = (state_r == ST_CH_PIX) ? font_data : din_r;
    assign vram_we   = we_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_zx_screen_writer.sv
// Directed bench for zx_screen_writer with a synchronous font ROM model that
// returns 8'hA0 + glyph line.
module tb_zx_screen_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_col;
    logic [4:0]  cmd_row;
    logic [7:0]  cmd_char;
    logic [7:0]  cmd_attr;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic [12:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_we;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int idle_we  = 0;
    int over_cnt = 0;
    int both_cnt = 0;

    zx_screen_writer dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_char  (cmd_char),
        .cmd_attr  (cmd_attr),
        .font_addr (font_addr),
        .font_data (font_data),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .vram_we   (vram_we),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) font_data <= {5'b10100, font_addr[2:0]};

    always @(posedge clk) begin
        if (vram_we) we_cnt++;
        if (vram_we && cmd_ready) idle_we++;
        if (vram_we && vram_addr > 13'd6911) over_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [4:0] row, input logic [4:0] col,
                         input logic [7:0] chr, input logic [7:0] attr);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_char  = chr;
        cmd_attr  = attr;
    endtask

    initial begin
        int base_cnt;
        int bad;
        logic [12:0] exp_a;
        logic [7:0]  exp_d;

        resetn = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 8'h00, 8'h00);
        cmd_valid = 1'b0;
        step(); step();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_din", 32'(vram_din), 32'd0);
        chk("rst_font", 32'(font_addr), 32'd0);
        resetn = 1'b1;
        step();

        // CHAR row 0 col 0 glyph 0x41 attr 0x38
        base_cnt = we_cnt;
        issue(1'b0, 5'd0, 5'd0, 8'h41, 8'h38);
        chk("c1_ready_at_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("c1_fetch_font", 32'(font_addr), 32'h208);
        chk("c1_fetch_busy", 32'({cmd_ready, vram_we}), 32'd0);
        for (int l = 0; l < 8; l++) begin
            step();
            chk($sformatf("c1_we_L%0d", l), 32'(vram_we), 32'd1);
            chk($sformatf("c1_addr_L%0d", l), 32'(vram_addr), 32'(l * 256));
            chk($sformatf("c1_din_L%0d", l), 32'(vram_din), 32'(8'hA0 + l));
            if (l < 7) chk($sformatf("c1_font_L%0d", l), 32'(font_addr), 32'(11'h208 + l + 1));
        end
        step();
        chk("c1_attr_addr", 32'(vram_addr), 32'h1800);
        chk("c1_attr_din", 32'(vram_din), 32'h38);
        chk("c1_attr_we", 32'(vram_we), 32'd1);
        step();
        chk("c1_done", 32'({done, vram_we, cmd_ready}), 32'b101);
        step();
        chk("c1_done_clear", 32'(done), 32'd0);
        chk("c1_writes", 32'(we_cnt - base_cnt), 32'd9);

        // CHAR row 23 col 31 glyph 0x00 attr 0x47
        base_cnt = we_cnt;
        issue(1'b0, 5'd23, 5'd31, 8'h00, 8'h47);
        step();
        cmd_valid = 1'b0;
        chk("c2_fetch_font", 32'(font_addr), 32'h000);
        for (int l = 0; l < 8; l++) begin
            step();
            chk($sformatf("c2_addr_L%0d", l), 32'(vram_addr), 32'(13'h10FF + l * 256));
            chk($sformatf("c2_din_L%0d", l), 32'(vram_din), 32'(8'hA0 + l));
        end
        step();
        chk("c2_attr", 32'({vram_addr, vram_din}), 32'({13'h1AFF, 8'h47}));
        step();
        chk("c2_done", 32'(done), 32'd1);
        chk("c2_writes", 32'(we_cnt - base_cnt), 32'd9);
        step();

        // CHAR row 24 is out of range
        base_cnt = we_cnt;
        issue(1'b0, 5'd24, 5'd3, 8'h55, 8'h01);
        step();
        cmd_valid = 1'b0;
        chk("c3_err", 32'({err, done, cmd_ready}), 32'b101);
        step();
        chk("c3_err_clear", 32'(err), 32'd0);
        step(); step();
        chk("c3_no_writes", 32'(we_cnt - base_cnt), 32'd0);
        chk("c3_ready", 32'(cmd_ready), 32'd1);

        // FILL attr 0x07
        base_cnt = we_cnt;
        bad = 0;
        issue(1'b1, 5'd31, 5'd31, 8'hFF, 8'h07);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6912; i++) begin
            if (i > 0) step();
            exp_a = 13'(i);
            exp_d = (i < 6144) ? 8'h00 : 8'h07;
            if (i == 0)    chk("f_first", 32'({vram_we, vram_addr, vram_din}), 32'({1'b1, 13'd0, 8'h00}));
            if (i == 6143) chk("f_pix_last", 32'({vram_addr, vram_din}), 32'({13'd6143, 8'h00}));
            if (i == 6144) chk("f_attr_first", 32'({vram_addr, vram_din}), 32'({13'd6144, 8'h07}));
            if (i == 6911) chk("f_last", 32'({vram_we, vram_addr, vram_din}), 32'({1'b1, 13'd6911, 8'h07}));
            if (vram_we !== 1'b1 || vram_addr !== exp_a || vram_din !== exp_d || done !== 1'b0) bad++;
        end
        chk("f_stream", 32'(bad), 32'd0);
        step();
        chk("f_done", 32'({done, vram_we, cmd_ready}), 32'b101);
        chk("f_writes", 32'(we_cnt - base_cnt), 32'd6912);
        step();

        // Reset in the middle of a FILL
        issue(1'b1, 5'd0, 5'd0, 8'h00, 8'h22);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("r_at_100", 32'({vram_we, vram_addr}), 32'({1'b1, 13'd100}));
        resetn = 1'b0;
        #1;
        chk("r_async_we", 32'(vram_we), 32'd0);
        step();
        resetn = 1'b1;
        base_cnt = we_cnt;
        step();
        chk("r_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("r_no_writes", 32'(we_cnt - base_cnt), 32'd0);

        // Back-to-back CHARs with cmd_valid held high
        issue(1'b0, 5'd1, 5'd2, 8'h10, 8'h11);
        for (int i = 0; i < 11; i++) step();
        chk("b_done_ready", 32'({done, cmd_ready}), 32'b11);
        cmd_char = 8'h22;
        step();
        cmd_valid = 1'b0;
        chk("b_second_font", 32'(font_addr), 32'h110);
        chk("b_second_busy", 32'(cmd_ready), 32'd0);
        step();
        chk("b_second_L0", 32'({vram_we, vram_addr, vram_din}), 32'({1'b1, 13'h0022, 8'hA0}));
        for (int i = 0; i < 10; i++) step();

        chk("g_idle_we", 32'(idle_we), 32'd0);
        chk("g_over", 32'(over_cnt), 32'd0);
        chk("g_done_err", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/zx_screen_writer.md
Name: zx_screen_writer

Overview:
Write-side engine for the dual-port ZX-format screen RAM (6144 pixel bytes + 768 attribute bytes) whose read side the video scan-out consumes. Accepts character-plot and screen-fill commands over a valid/ready handshake. Fetches glyph rows from an external synchronous font ROM. Writes pixel and attribute bytes through the RAM write port using Spectrum interleaved addressing.

Parameters:
ADDR_W, 13, screen RAM address width
ATTR_BASE, 6144, first attribute byte address
ROWS, 24, character rows on screen
COLS, 32, character columns on screen

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready
cmd_op  in  1  0 = CHAR, 1 = FILL
cmd_col  in  5  character column 0..31
cmd_row  in  5  character row 0..23
cmd_char  in  8  glyph code (CHAR only)
cmd_attr  in  8  attribute byte (CHAR: cell attribute; FILL: whole-screen attribute)
font_addr  out  11  {glyph, line[2:0]} to font ROM
font_data  in  8  glyph row; valid one cycle after font_addr is driven
vram_addr  out  ADDR_W  screen RAM write address
vram_din  out  8  screen RAM write data
vram_we  out  1  write strobe; one byte per asserted cycle
done  out  1  one-cycle pulse after the final write of a command
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async, resetn=0): state IDLE. Outputs: cmd_ready=1, vram_we=0, done=0, err=0, vram_addr=0, vram_din=0, font_addr=0. Reset mid-command abandons the command at once; vram_we drops asynchronously and no further writes occur.
- States: IDLE, CH_FETCH, CH_PIX, CH_ATTR, FL_PIX, FL_ATTR. cmd_ready=1 only in IDLE.
- Command inputs are latched at acceptance. They are ignored while busy.
- Row check: a CHAR with cmd_row >= ROWS is rejected. err pulses in cycle A+1 (A = accept cycle). No RAM writes occur, state stays IDLE, cmd_ready stays 1. FILL ignores row and col.
- CHAR timing:
  - A+1: font_addr = {char, 3'd0} (CH_FETCH).
  - A+2..A+9: CH_PIX, line L = 0..7. vram_we=1, vram_din = font_data for line L. vram_addr = {row[4:3], L[2:0], row[2:0], col[4:0]}. font_addr advances to line L+1 in the same cycle (pipelined; no bubble).
  - A+10: CH_ATTR. vram_we=1, vram_addr = ATTR_BASE + {row, col} (10-bit sum, zero-extended to ADDR_W), vram_din = attr.
  - A+11: done=1, vram_we=0, IDLE, cmd_ready=1.
  - Total: 9 writes, 11-cycle busy window.
- FILL timing:
  - A+1..A+6144: FL_PIX. vram_addr counts 0..6143, vram_din=8'h00.
  - A+6145..A+6912: FL_ATTR. vram_addr counts 6144..6911, vram_din=attr.
  - A+6913: done=1, IDLE.
  - Address counter rolls from 6143 into 6144 with no gap and never exceeds 6911.
- vram_we is never asserted in IDLE. vram_addr/vram_din keep their last values when vram_we=0.
- done and err are never asserted in the same cycle.
- Back-to-back: a new command may be accepted in the cycle done pulses (cmd_ready=1 there). Its first write follows that command's own timing.
- Write port runs on clk. The read port of the shared RAM is independent; no arbitration is needed (simple dual-port).

Decomposition:
- Shared package zx_screen_pkg: ATTR_BASE, PIX_BYTES=6144, ATTR_BYTES=768, ROWS, COLS, op encodings (OP_CHAR, OP_FILL), and a function pix_addr(y[7:0], col[4:0]) returning {y[7:6], y[2:0], y[5:3], col}.
- The scan-out side reuses the same function.
- Sub-module: zx_addr_gen, a combinational pixel/attribute address mapper taking row, line, and col. Instanced once here and shared with the display path.

Test Plan:
- CHAR row=0 col=0 char=8'h41 attr=8'h38, ROM returns 8'hA0+L -> writes at 0x0000,0x0100,..,0x0700 with data A0..A7, then 0x1800=0x38; done at A+11.
- CHAR row=23 col=31 char=8'h00 attr=8'h47 -> pixel addrs {2'b10,L,3'b111,5'h1F} (0x10FF..0x17FF step 0x100), attr addr 0x1AFF; 9 writes total.
- CHAR row=24 -> err pulse at A+1, zero vram_we cycles, cmd_ready stays 1.
- FILL attr=8'h07 -> 6912 consecutive writes: 0..6143 data 0x00, 6144..6911 data 0x07; done at A+6913; no address >6911.
- resetn low at FILL address 100 -> vram_we 0 immediately; after release cmd_ready=1, no writes without a new command.
- Two CHAR commands with cmd_valid held high -> second accepted in the done cycle of the first; font_addr for its line 0 appears next cycle.
